// File: rtl/usb_pkg.sv
// Shared definitions for the full-speed USB transmit path.
// Line states are packed as {dp, dn}.
package usb_pkg;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam logic [7:0] SYNC_BYTE    = 8'h80;
   localparam int         STUFF_LIMIT  = 6;
   localparam int         EOP_SE0_BITS = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_e;

endpackage

// File: rtl/usb_tx_bit_encoder.sv
// NRZI encoder with bit stuffing for the USB transmitter.
// Ports:
//   clk48, rst_n : clock and asynchronous active-low reset
//   clear        : return line level to J and clear the ones run (between packets)
//   strobe       : advance one line bit
//   bit_in       : data bit to send on this strobe (ignored when stall is high)
//   stall        : a stuff bit is owed; the strobe sends it instead of bit_in
//   k_next       : line level (1 = K) that this strobe produces
module usb_tx_bit_encoder
   import usb_pkg::*;
(
   input  logic clk48,
   input  logic rst_n,
   input  logic clear,
   input  logic strobe,
   input  logic bit_in,
   output logic stall,
   output logic k_next
);

   logic       level_k;
   logic [2:0] ones;

   // Six 1s in a row leave a stuff bit owed; it goes out on the next strobe.
   assign stall  = (ones == 3'(STUFF_LIMIT));
   assign k_next = (stall || !bit_in) ? ~level_k : level_k;

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         level_k <= 1'b0;
         ones    <= '0;
      end else if (clear) begin
         level_k <= 1'b0;
         ones    <= '0;
      end else if (strobe) begin
         level_k <= k_next;
         ones    <= (stall || !bit_in) ? '0 : ones + 3'd1;
      end
   end

endmodule

// File: rtl/usb_tx.sv
// Full-speed USB low-level transmitter: SYNC, buffer bytes (NRZI + stuffing), EOP.
// Ports:
//   clk48, rst_n : 48 MHz clock, asynchronous active-low reset
//   start, length: transmit request and byte count (0..1024), sampled in IDLE
//   buf_addr     : word address into the 32-bit USB data buffer
//   buf_rdata    : buffer read data, one cycle after buf_addr
//   tx_en, tx_dp, tx_dn : line driver enable and levels
//   busy, done   : transmission in progress / one-cycle completion pulse
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | line released at J, waiting for start
// ST_SYNC    | sending the SYNC byte
// ST_DATA    | sending buffer bytes plus any trailing stuff bit
// ST_EOP_SE0 | two bit times of SE0
// ST_EOP_J   | one bit time of J, then done
module usb_tx
   import usb_pkg::*;
#(
   parameter int BUFFER_WORDS = 256,
   parameter int CLKS_PER_BIT = 4
)(
   input  logic        clk48,
   input  logic        rst_n,
   input  logic        start,
   input  logic [10:0] length,
   output logic [7:0]  buf_addr,
   input  logic [31:0] buf_rdata,
   output logic        tx_en,
   output logic        tx_dp,
   output logic        tx_dn,
   output logic        busy,
   output logic        done
);

   localparam int            PW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [PW-1:0] PHASE_LOAD = PW'(CLKS_PER_BIT - 1);
   localparam logic [7:0]    ADDR_MASK  = 8'(BUFFER_WORDS - 1);

   tx_state_e     state;
   logic [PW-1:0] phase;
   logic [2:0]    bit_idx;
   logic [10:0]   byte_cnt;
   logic [10:0]   len_q;
   logic [7:0]    sreg;
   logic          tail;

   logic       go;
   logic       bit_end;
   logic       shifting;
   logic       enc_strobe;
   logic       enc_bit;
   logic       enc_stall;
   logic       enc_k_next;
   logic [7:0] next_byte;

   assign go       = (state == ST_IDLE) && start && (length != '0);
   assign bit_end  = (phase == '0);
   assign shifting = (state == ST_SYNC) || (state == ST_DATA);

   // Once the last data bit is out (tail), a strobe only happens for an owed stuff bit.
   assign enc_strobe = go || (shifting && bit_end && (enc_stall || !tail));
   assign enc_bit    = go ? SYNC_BYTE[0] : sreg[0];

   // buf_addr tracks the word of the next byte to load, so the word is
   // addressed a full byte time before its lane is taken.
   assign buf_addr  = byte_cnt[9:2] & ADDR_MASK;
   assign next_byte = buf_rdata[{byte_cnt[1:0], 3'b000} +: 8];

   usb_tx_bit_encoder u_enc (
      .clk48  (clk48),
      .rst_n  (rst_n),
      .clear  (state == ST_EOP_J),
      .strobe (enc_strobe),
      .bit_in (enc_bit),
      .stall  (enc_stall),
      .k_next (enc_k_next)
   );

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         phase          <= '0;
         bit_idx        <= '0;
         byte_cnt       <= '0;
         len_q          <= '0;
         sreg           <= '0;
         tail           <= 1'b0;
         tx_en          <= 1'b0;
         {tx_dp, tx_dn} <= LINE_J;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done  <= 1'b0;
         phase <= bit_end ? PHASE_LOAD : phase - PW'(1);
         if (enc_strobe) {tx_dp, tx_dn} <= enc_k_next ? LINE_K : LINE_J;

         case (state)
            ST_IDLE: begin
               phase <= PHASE_LOAD;
               if (start) begin
                  if (length == '0) begin
                     done <= 1'b1;
                  end else begin
                     state    <= ST_SYNC;
                     len_q    <= length;
                     byte_cnt <= '0;
                     sreg     <= {1'b0, SYNC_BYTE[7:1]};
                     bit_idx  <= 3'd6;
                     tail     <= 1'b0;
                     tx_en    <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            ST_SYNC, ST_DATA: begin
               if (bit_end && !enc_stall) begin
                  if (tail) begin
                     state          <= ST_EOP_SE0;
                     {tx_dp, tx_dn} <= LINE_SE0;
                     bit_idx        <= 3'(EOP_SE0_BITS - 1);
                  end else if (bit_idx == '0) begin
                     state   <= ST_DATA;
                     bit_idx <= 3'd7;
                     if (byte_cnt < len_q) begin
                        sreg     <= next_byte;
                        byte_cnt <= byte_cnt + 11'd1;
                     end else begin
                        tail <= 1'b1;
                     end
                  end else begin
                     sreg    <= {1'b0, sreg[7:1]};
                     bit_idx <= bit_idx - 3'd1;
                  end
               end
            end
            ST_EOP_SE0: begin
               if (bit_end) begin
                  if (bit_idx == '0) begin
                     state          <= ST_EOP_J;
                     {tx_dp, tx_dn} <= LINE_J;
                  end else begin
                     bit_idx <= bit_idx - 3'd1;
                  end
               end
            end
            ST_EOP_J: begin
               if (bit_end) begin
                  state <= ST_IDLE;
                  tx_en <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx.sv
// Testbench for usb_tx: directed vector table, randomized packets against a
// bit-level reference model, and hand-written boundary/reset sequences.
`timescale 1ns/1ps
module tb_usb_tx;

   localparam int CPB = 4;

   logic        clk48 = 1'b0;
   logic        rst_n;
   logic        start;
   logic [10:0] length;
   logic [7:0]  buf_addr;
   logic [31:0] buf_rdata;
   logic        tx_en, tx_dp, tx_dn, busy, done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [256];
   logic [1:0]  exp_q [$];

   typedef struct {
      int          len;
      logic [31:0] w0;
      logic [31:0] w1;
      int          en_cycles;
      int          max_addr;
   } vec_t;

   usb_tx #(.BUFFER_WORDS(256), .CLKS_PER_BIT(CPB)) dut (
      .clk48     (clk48),
      .rst_n     (rst_n),
      .start     (start),
      .length    (length),
      .buf_addr  (buf_addr),
      .buf_rdata (buf_rdata),
      .tx_en     (tx_en),
      .tx_dp     (tx_dp),
      .tx_dn     (tx_dn),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk48 = ~clk48;

   always @(posedge clk48) buf_rdata <= mem[buf_addr];

   function automatic logic [7:0] get_byte(input int i);
      logic [31:0] w;
      w = mem[i / 4];
      return w[8 * (i % 4) +: 8];
   endfunction

   function automatic void set_byte(input int i, input logic [7:0] v);
      mem[i / 4][8 * (i % 4) +: 8] = v;
   endfunction

   // Reference line sequence, one {dp,dn} symbol per bit time:
   // raw bit list -> stuff after every sixth consecutive 1 -> NRZI from J -> SE0 SE0 J.
   function automatic void build_expected(input int len);
      bit   raw [$];
      int   ones;
      bit   lvl_k;
      logic [7:0] by;
      exp_q.delete();
      for (int b = 0; b < 8; b++) raw.push_back(b == 7);
      for (int i = 0; i < len; i++) begin
         by = get_byte(i);
         for (int b = 0; b < 8; b++) raw.push_back(by[b]);
      end
      ones  = 0;
      lvl_k = 1'b0;
      foreach (raw[i]) begin
         if (raw[i]) ones++;
         else begin
            ones  = 0;
            lvl_k = !lvl_k;
         end
         exp_q.push_back(lvl_k ? 2'b01 : 2'b10);
         if (ones == 6) begin
            lvl_k = !lvl_k;
            ones  = 0;
            exp_q.push_back(lvl_k ? 2'b01 : 2'b10);
         end
      end
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Sends one packet of len bytes (buffer already loaded) and checks the line
   // cycle by cycle. poke_at >= 0 pulses start again at that cycle of the packet.
   task automatic run_packet(input string name, input int len, input int exp_en,
                             input int poke_at, output int first_addr, output int max_addr);
      int         en_cnt, line_err, done_at, n_exp, post_act;
      logic [3:0] after;
      build_expected(len);
      n_exp      = (len == 0) ? 0 : exp_q.size() * CPB;
      en_cnt     = 0;
      line_err   = 0;
      done_at    = -1;
      first_addr = -1;
      max_addr   = 0;
      after      = 4'hF;
      post_act   = 0;
      @(posedge clk48); #1;
      start  = 1'b1;
      length = 11'(len);
      @(posedge clk48); #1;
      start  = 1'b0;
      for (int c = 0; c < n_exp + 40 && done_at < 0; c++) begin
         if (tx_en) en_cnt++;
         if (busy) begin
            if (first_addr < 0) first_addr = buf_addr;
            if (int'(buf_addr) > max_addr) max_addr = buf_addr;
         end
         if (c < n_exp && (!tx_en || !busy || {tx_dp, tx_dn} !== exp_q[c / CPB])) line_err++;
         if (done) begin
            done_at = c;
            after   = {tx_en, busy, tx_dp, tx_dn};
         end
         if (c == poke_at) begin
            start  = 1'b1;
            length = 11'd3;
         end else begin
            start = 1'b0;
         end
         if (done_at < 0) begin
            @(posedge clk48); #1;
         end
      end
      start = 1'b0;
      check({name, " line"}, line_err, 0);
      check({name, " tx_en_cycles"}, en_cnt, exp_en);
      check({name, " done_cycle"}, done_at, n_exp);
      check({name, " state_at_done"}, after, 4'b0010);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk48); #1;
         if (tx_en || done || busy) post_act++;
      end
      check({name, " quiet_after"}, post_act, 0);
   endtask

   initial begin
      vec_t vecs [5];
      int   fa, ma, len, quiet;

      rst_n  = 1'b0;
      start  = 1'b0;
      length = '0;
      foreach (mem[i]) mem[i] = '0;

      vecs[0] = '{1, 32'h0000_00D2, 32'h0, 76,  0};
      vecs[1] = '{2, 32'h0000_FFFF, 32'h0, 116, 0};
      vecs[2] = '{1, 32'h0000_00FC, 32'h0, 80,  0};
      vecs[3] = '{6, 32'h0403_0201, 32'h0000_0605, 236, 1};
      vecs[4] = '{0, 32'h0, 32'h0, 0, 0};

      #12;
      check("reset_outputs", {tx_en, tx_dp, tx_dn, busy, done, buf_addr}, {5'b01000, 8'h00});
      #10 rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         mem[0] = vecs[v].w0;
         mem[1] = vecs[v].w1;
         run_packet($sformatf("vec%0d", v), vecs[v].len, vecs[v].en_cycles, -1, fa, ma);
         if (vecs[v].len > 0) begin
            check($sformatf("vec%0d first_addr", v), fa, 0);
            check($sformatf("vec%0d max_addr", v), ma, vecs[v].max_addr);
         end
      end

      for (int p = 0; p < 16; p++) begin
         len = $urandom_range(1, 32);
         for (int i = 0; i < len; i++)
            set_byte(i, ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
         build_expected(len);
         run_packet($sformatf("rand%0d", p), len, exp_q.size() * CPB, -1, fa, ma);
      end

      // start while busy must not disturb the packet in flight
      for (int i = 0; i < 4; i++) set_byte(i, 8'($urandom));
      build_expected(4);
      run_packet("start_busy", 4, exp_q.size() * CPB, 50, fa, ma);

      // maximum length: no counter wrap, last word reached
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      build_expected(1024);
      run_packet("len1024", 1024, exp_q.size() * CPB, -1, fa, ma);
      check("len1024 max_addr", ma, 255);

      // asynchronous reset during the third data byte
      for (int i = 0; i < 8; i++) set_byte(i, 8'h55 ^ 8'(i));
      @(posedge clk48); #1;
      start  = 1'b1;
      length = 11'd8;
      @(posedge clk48); #1;
      start  = 1'b0;
      repeat (100) @(posedge clk48);
      #1;
      check("rst_pre_active", tx_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {tx_en, busy, tx_dp, tx_dn, done}, 5'b00100);
      quiet = 0;
      repeat (3) begin
         @(posedge clk48); #1;
         if (tx_en || busy || done) quiet++;
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk48); #1;
         if (tx_en || busy || done) quiet++;
      end
      check("rst_quiet", quiet, 0);
      build_expected(8);
      run_packet("after_reset", 8, exp_q.size() * CPB, -1, fa, ma);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
